// File: rtl/layer_trainer_if.sv
// Signal bundle between layer_trainer and its host/layer: sample loading,
// run control, and the layer strobe/data path. zero2one_t is a W-bit fraction.
interface layer_trainer_if #(
  parameter int N = 16,
  parameter int M = 43,
  parameter int W = 8
);
  typedef logic [W-1:0] zero2one_t;

  logic                clr;
  logic                ld_valid;
  logic                ld_ready;
  zero2one_t [N-1:0]   ld_in;
  zero2one_t [M-1:0]   ld_expected;
  logic                start;
  logic [15:0]         epochs;
  logic                busy;
  logic                done;
  logic [15:0]         mismatch;
  logic                valid;
  logic                learn;
  zero2one_t [N-1:0]   in;
  zero2one_t [M-1:0]   expected_out;
  zero2one_t [M-1:0]   out;

  modport master (
    output clr, ld_valid, ld_in, ld_expected, start, epochs, out,
    input  ld_ready, busy, done, mismatch, valid, learn, in, expected_out
  );

  modport slave (
    input  clr, ld_valid, ld_in, ld_expected, start, epochs, out,
    output ld_ready, busy, done, mismatch, valid, learn, in, expected_out
  );
endinterface

// File: rtl/layer_trainer.sv
// Replays a buffer of {input, target} samples through a layer for a number of epochs
// and counts target mismatches in the final pass. Define LAYER_TRAINER_EVAL_EN for an extra learn=0 evaluation pass.
module layer_trainer #(
  parameter int N     = 16,
  parameter int M     = 43,
  parameter int DEPTH = 8,
  parameter int LAT   = 1,
  parameter int TOL   = 0,
  parameter int W     = 8
) (
  input logic            clock,
  input logic            reset_n,
  layer_trainer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = $clog2(M + 1);
  localparam int DW = W + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT, CHECK} state_t;
  typedef logic [N-1:0][W-1:0] in_vec_t;
  typedef logic [M-1:0][W-1:0] exp_vec_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic [15:0]   epoch_cnt;
  logic [15:0]   last_epoch;
  logic [15:0]   wait_cnt;

  in_vec_t  mem_in  [DEPTH];
  exp_vec_t mem_exp [DEPTH];

  logic          load_fire;
  logic          final_pass;
  logic          last_sample;
  logic [AW-1:0] next_idx;
  logic [15:0]   next_epoch;
  logic          next_learn;
  logic [MW-1:0] sample_miss;
  logic [16:0]   mm_sum;

  assign bus.ld_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire    = bus.ld_valid && bus.ld_ready && !bus.clr;
  assign final_pass   = (epoch_cnt == last_epoch);
  assign last_sample  = ({1'b0, idx} == count - CW'(1));
  assign next_idx     = last_sample ? '0 : idx + AW'(1);
  assign next_epoch   = last_sample ? epoch_cnt + 16'd1 : epoch_cnt;
`ifdef LAYER_TRAINER_EVAL_EN
  assign next_learn   = (next_epoch != last_epoch);
`else
  assign next_learn   = 1'b1;
`endif

  // One extra bit keeps the subtraction from wrapping before the tolerance compare.
  function automatic logic [DW-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [DW-1:0] wa, wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? wa - wb : wb - wa;
  endfunction

  always_comb begin
    sample_miss = '0;
    for (int k = 0; k < M; k++) begin
      if (abs_diff(bus.out[k], bus.expected_out[k]) > DW'(TOL))
        sample_miss = sample_miss + MW'(1);
    end
    mm_sum = {1'b0, bus.mismatch} + 17'(sample_miss);
  end

  always_ff @(posedge clock) begin
    if (reset_n && load_fire) begin
      mem_in[count[AW-1:0]]  <= bus.ld_in;
      mem_exp[count[AW-1:0]] <= bus.ld_expected;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= IDLE;
      count            <= '0;
      idx              <= '0;
      epoch_cnt        <= '0;
      last_epoch       <= '0;
      wait_cnt         <= '0;
      bus.valid        <= 1'b0;
      bus.learn        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.mismatch     <= '0;
      bus.in           <= '0;
      bus.expected_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr)
            count <= '0;
          else if (load_fire)
            count <= count + CW'(1);
          if (bus.start) begin
            bus.mismatch <= '0;
            if (count != '0 && bus.epochs != 16'd0) begin
              state            <= PRESENT;
              idx              <= '0;
              epoch_cnt        <= '0;
`ifdef LAYER_TRAINER_EVAL_EN
              last_epoch       <= bus.epochs;
`else
              last_epoch       <= bus.epochs - 16'd1;
`endif
              bus.busy         <= 1'b1;
              bus.valid        <= 1'b1;
              bus.learn        <= 1'b1;
              bus.in           <= mem_in[0];
              bus.expected_out <= mem_exp[0];
            end else begin
              bus.done <= 1'b1;
            end
          end
        end
        PRESENT: begin
          bus.valid <= 1'b0;
          bus.learn <= 1'b0;
          wait_cnt  <= 16'(LAT - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 16'd0)
            state <= CHECK;
          else
            wait_cnt <= wait_cnt - 16'd1;
        end
        CHECK: begin
          // Mismatches only accumulate in the final pass and saturate at 16'hFFFF.
          if (final_pass)
            bus.mismatch <= mm_sum[16] ? 16'hFFFF : mm_sum[15:0];
          if (last_sample && final_pass) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            idx       <= '0;
            epoch_cnt <= '0;
          end else begin
            state            <= PRESENT;
            idx              <= next_idx;
            epoch_cnt        <= next_epoch;
            bus.valid        <= 1'b1;
            bus.learn        <= next_learn;
            bus.in           <= mem_in[next_idx];
            bus.expected_out <= mem_exp[next_idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_trainer.sv
// Directed bench for layer_trainer: a schedule/arithmetic model of each run is checked every cycle,
// plus literal expectations for load limits, run latency, tolerance and abort behaviour.
module tb_layer_trainer;
  localparam int N     = 16;
  localparam int M     = 43;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int LAT   = 1;
  localparam int TOL   = 1;
`ifdef LAYER_TRAINER_EVAL_EN
  localparam int EVAL_EN = 1;
`else
  localparam int EVAL_EN = 0;
`endif

  typedef logic [N-1:0][W-1:0] in_vec_t;
  typedef logic [M-1:0][W-1:0] exp_vec_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  layer_trainer_if #(.N(N), .M(M), .W(W)) bus ();
  layer_trainer_if #(.N(N), .M(M), .W(W)) bus2 ();

  layer_trainer #(.N(N), .M(M), .DEPTH(DEPTH), .LAT(LAT), .TOL(TOL), .W(W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  layer_trainer #(.N(N), .M(M), .DEPTH(DEPTH), .LAT(LAT), .TOL(2), .W(W)) dut_tol2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2)
  );

  assign bus2.clr         = bus.clr;
  assign bus2.ld_valid    = bus.ld_valid;
  assign bus2.ld_in       = bus.ld_in;
  assign bus2.ld_expected = bus.ld_expected;
  assign bus2.start       = bus.start;
  assign bus2.epochs      = bus.epochs;

  int delta = 0;

  // Layer stub: first five outputs are offset from the target by delta.
  always_comb begin
    bus.out  = bus.expected_out;
    bus2.out = bus2.expected_out;
    for (int k = 0; k < 5; k++) begin
      bus.out[k]  = bus.expected_out[k] + 8'(delta);
      bus2.out[k] = bus2.expected_out[k] + 8'(delta);
    end
  end

  int total = 0;
  int bad   = 0;

  in_vec_t  sb_in  [DEPTH];
  exp_vec_t sb_exp [DEPTH];
  int model_count = 0;

  bit model_on = 0;
  bit chk_idle = 0;
  int rel, run_len, run_count, run_epochs;
  int exp_mm = 0, exp_mm2 = 0;
  int valid_pulses, learn_pulses, busy_seen, done_at;
  int q, s, pass;
  bit exp_v, exp_l;

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic in_vec_t make_in(input int seed);
    in_vec_t v;
    for (int k = 0; k < N; k++) v[k] = 8'((seed * 7 + k * 3 + 1) % 256);
    return v;
  endfunction

  function automatic exp_vec_t make_exp(input int seed);
    exp_vec_t v;
    for (int k = 0; k < M; k++) v[k] = 8'(10 + (seed * 13 + k * 5) % 200);
    return v;
  endfunction

  // Mismatches one pass over the buffer produces against the stub, for a given tolerance.
  function automatic int model_miss(input int tol);
    int n = 0;
    for (int si = 0; si < run_count; si++) begin
      for (int k = 0; k < M; k++) begin
        int e, o, d;
        e = int'(sb_exp[si][k]);
        o = (k < 5) ? ((e + delta) % 256 + 256) % 256 : e;
        d = (o > e) ? o - e : e - o;
        if (d > tol) n++;
      end
    end
    return (n > 65535) ? 65535 : n;
  endfunction

  always @(negedge clock) begin
    if (model_on) begin
      rel = rel + 1;
      if (bus.valid) valid_pulses++;
      if (bus.learn) learn_pulses++;
      if (bus.busy)  busy_seen++;
      if (bus.done && done_at == 0) done_at = rel;
      if (rel <= run_len) begin
        q     = (rel - 1) / (LAT + 2);
        s     = q % run_count;
        pass  = q / run_count;
        exp_v = ((rel - 1) % (LAT + 2)) == 0;
        exp_l = exp_v && !(EVAL_EN == 1 && pass == run_epochs);
        check_output("run_busy",  512'(bus.busy),  512'(1'b1));
        check_output("run_done",  512'(bus.done),  512'(1'b0));
        check_output("run_valid", 512'(bus.valid), 512'(exp_v));
        check_output("run_learn", 512'(bus.learn), 512'(exp_l));
        check_output("run_in",    512'(bus.in),    512'(sb_in[s]));
        check_output("run_expected_out", 512'(bus.expected_out), 512'(sb_exp[s]));
      end else begin
        check_output("end_done",     512'(bus.done),      512'(1'b1));
        check_output("end_busy",     512'(bus.busy),      512'(1'b0));
        check_output("end_valid",    512'(bus.valid),     512'(1'b0));
        check_output("end_mismatch", 512'(bus.mismatch),  512'(exp_mm));
        check_output("end_mismatch_tol2", 512'(bus2.mismatch), 512'(exp_mm2));
        model_on = 0;
      end
    end else if (chk_idle) begin
      check_output("idle_busy",     512'(bus.busy),     512'(1'b0));
      check_output("idle_done",     512'(bus.done),     512'(1'b0));
      check_output("idle_valid",    512'(bus.valid),    512'(1'b0));
      check_output("idle_learn",    512'(bus.learn),    512'(1'b0));
      check_output("idle_mismatch", 512'(bus.mismatch), 512'(exp_mm));
      check_output("idle_ld_ready", 512'(bus.ld_ready), 512'(model_count < DEPTH));
    end
  end

  task automatic apply_stimulus(input int seed);
    in_vec_t  vi;
    exp_vec_t ve;
    vi = make_in(seed);
    ve = make_exp(seed);
    @(posedge clock); #1;
    bus.ld_valid = 1'b1; bus.ld_in = vi; bus.ld_expected = ve;
    @(posedge clock); #1;
    bus.ld_valid = 1'b0;
    if (model_count < DEPTH) begin
      sb_in[model_count]  = vi;
      sb_exp[model_count] = ve;
      model_count++;
    end
  endtask

  task automatic clear_buffer(input bit with_load);
    @(posedge clock); #1;
    bus.clr = 1'b1; bus.ld_valid = with_load; bus.ld_in = make_in(99); bus.ld_expected = make_exp(99);
    @(posedge clock); #1;
    bus.clr = 1'b0; bus.ld_valid = 1'b0;
    model_count = 0;
  endtask

  // Mid-run start/clr pokes must be ignored, so the model expects an unchanged run.
  task automatic run_train(input int ep, input bit poke);
    int mm, mm2;
    run_count  = model_count;
    run_epochs = ep;
    run_len    = (run_count == 0 || ep == 0) ? 0 : (ep + EVAL_EN) * run_count * (LAT + 2);
    mm         = (run_len == 0) ? 0 : model_miss(TOL);
    mm2        = (run_len == 0) ? 0 : model_miss(2);
    valid_pulses = 0; learn_pulses = 0; busy_seen = 0; done_at = 0;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.epochs = 16'(ep);
    @(posedge clock); #1;
    bus.start = 1'b0;
    exp_mm = mm; exp_mm2 = mm2; rel = 0; model_on = 1;
    if (poke) begin
      repeat (4) @(posedge clock);
      #1 bus.start = 1'b1; bus.clr = 1'b1; bus.epochs = 16'd7;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.clr = 1'b0; bus.epochs = 16'(ep);
    end
    for (int i = 0; i < run_len + 8 && model_on; i++) @(negedge clock);
    if (model_on) begin
      model_on = 0;
      check_output("run_timeout", 512'(1'b1), 512'(1'b0));
    end
  endtask

  task automatic abort_run();
    chk_idle = 0;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.epochs = 16'd2;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    check_output("abort_present_valid", 512'(bus.valid), 512'(1'b1));
    @(negedge clock);
    check_output("abort_wait_busy",  512'(bus.busy),  512'(1'b1));
    check_output("abort_wait_valid", 512'(bus.valid), 512'(1'b0));
    reset_n = 1'b0;
    @(negedge clock);
    check_output("abort_busy",     512'(bus.busy),     512'(1'b0));
    check_output("abort_valid",    512'(bus.valid),    512'(1'b0));
    check_output("abort_done",     512'(bus.done),     512'(1'b0));
    check_output("abort_mismatch", 512'(bus.mismatch), 512'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_count = 0; exp_mm = 0; chk_idle = 1;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    bus.clr = 1'b0; bus.ld_valid = 1'b0; bus.start = 1'b0; bus.epochs = 16'd0;
    bus.ld_in = '0; bus.ld_expected = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_output("reset_busy",     512'(bus.busy),         512'(1'b0));
    check_output("reset_done",     512'(bus.done),         512'(1'b0));
    check_output("reset_valid",    512'(bus.valid),        512'(1'b0));
    check_output("reset_mismatch", 512'(bus.mismatch),     512'(0));
    check_output("reset_ld_ready", 512'(bus.ld_ready),     512'(1'b1));
    check_output("reset_in",       512'(bus.in),           512'(0));
    check_output("reset_exp_out",  512'(bus.expected_out), 512'(0));
    chk_idle = 1;

    for (int i = 0; i < 3; i++) apply_stimulus(i);
    @(negedge clock);
    check_output("ready_after_3", 512'(bus.ld_ready), 512'(1'b1));
    for (int i = 3; i < 8; i++) apply_stimulus(i);
    @(negedge clock);
    check_output("ready_after_8", 512'(bus.ld_ready), 512'(1'b0));
    apply_stimulus(8);
    @(negedge clock);
    check_output("ready_after_9th", 512'(bus.ld_ready), 512'(1'b0));
    run_train(1, 0);

    clear_buffer(1'b0);
    apply_stimulus(10);
    apply_stimulus(11);
    delta = 0;
    run_train(2, 0);
    check_output("lat1_done_cycle", 512'(done_at),      512'(EVAL_EN ? 19 : 13));
    check_output("lat1_valids",     512'(valid_pulses), 512'(EVAL_EN ? 6 : 4));
    check_output("lat1_mismatch",   512'(bus.mismatch), 512'(0));

    delta = 2;
    run_train(1, 0);
    check_output("tol1_plus2", 512'(bus.mismatch),  512'(10));
    check_output("tol2_plus2", 512'(bus2.mismatch), 512'(0));

    delta = -3;
    run_train(3, 1);
    check_output("tol1_minus3_poked", 512'(bus.mismatch), 512'(10));

    delta = 1;
    run_train(1, 0);
    check_output("tol1_plus1", 512'(bus.mismatch), 512'(0));

    delta = 0;
    run_train(1, 0);
    check_output("epoch1_valids", 512'(valid_pulses), 512'(EVAL_EN ? 4 : 2));
    check_output("epoch1_learns", 512'(learn_pulses), 512'(2));

    run_train(0, 0);
    check_output("zero_epochs_done", 512'(done_at),   512'(1));
    check_output("zero_epochs_busy", 512'(busy_seen), 512'(0));

    clear_buffer(1'b1);
    run_train(1, 0);
    check_output("clr_wins_done",  512'(done_at),      512'(1));
    check_output("clr_wins_valid", 512'(valid_pulses), 512'(0));
    check_output("clr_wins_busy",  512'(busy_seen),    512'(0));

    apply_stimulus(20);
    apply_stimulus(21);
    abort_run();
    run_train(2, 0);
    check_output("post_abort_done", 512'(done_at),      512'(1));
    check_output("post_abort_valid", 512'(valid_pulses), 512'(0));

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
